// File: rtl/rv32_shared_sram_arb.sv
// Shared single-port SRAM serving one RV32 CPU port and NUM_CH DMA channels.
// Round-robin DMA arbitration with burst lock and a CPU starvation bound; RV32_ARB_STATS_EN adds a CPU stall counter.
module rv32_shared_sram_arb #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_we,
  input  logic [DATA_W/8-1:0]      cpu_be,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [DATA_W-1:0]        cpu_rdata,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_lock,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata
`ifdef RV32_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [31:0]              cpu_stall_cnt
`endif
);

  localparam int          BE_W   = DATA_W / 8;
  localparam int          WORD_W = ADDR_W - 2;
  localparam int          DEPTH  = 1 << WORD_W;
  localparam int          PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          CNT_W  = 8;
  localparam int unsigned NCH    = NUM_CH;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    owner, owner_nxt, rr_ptr, sel;
  logic                sel_valid, force_cpu, lock_hold;
  logic [CNT_W-1:0]    starve_cnt;
  logic                gnt_cpu, any_gnt, wr_en;
  logic [NUM_CH-1:0]   gnt_ch;
  logic [WORD_W-1:0]   word;
  logic [BE_W-1:0]     wr_be;
  logic [DATA_W-1:0]   wr_data;
  logic                unused_lsb;
  int unsigned         idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  // A lock is honoured only while its owner keeps both req and lock high;
  // otherwise this cycle falls through to ordinary round-robin.
  always_comb begin
    force_cpu = cpu_req && (starve_cnt == CNT_W'(MAX_WAIT));
    lock_hold = (state == LOCKED) && ch_req[owner] && ch_lock[owner];
    sel       = '0;
    sel_valid = 1'b0;
    idx       = 0;
    if (lock_hold) begin
      sel       = owner;
      sel_valid = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = (32'(rr_ptr) + k) % NCH;
        if (!sel_valid && ch_req[idx]) begin
          sel       = PTR_W'(idx);
          sel_valid = 1'b1;
        end
      end
    end
    gnt_cpu = 1'b0;
    gnt_ch  = '0;
    if (rst_n) begin
      if (force_cpu)      gnt_cpu = 1'b1;
      else if (sel_valid) gnt_ch[sel] = 1'b1;
      else                gnt_cpu = cpu_req;
    end
    state_nxt = IDLE;
    owner_nxt = owner;
    if (lock_hold) begin
      state_nxt = LOCKED;
    end else if (|gnt_ch && ch_lock[sel]) begin
      state_nxt = LOCKED;
      owner_nxt = sel;
    end
  end

  always_comb begin
    any_gnt = gnt_cpu || (|gnt_ch);
    if (gnt_cpu) begin
      word    = cpu_addr[ADDR_W-1:2];
      wr_en   = cpu_we;
      wr_be   = cpu_be;
      wr_data = cpu_wdata;
    end else begin
      word    = ch_addr[int'(sel)*ADDR_W + 2 +: WORD_W];
      wr_en   = ch_we[sel];
      wr_be   = '1;
      wr_data = ch_wdata[int'(sel)*DATA_W +: DATA_W];
    end
    unused_lsb = ^cpu_addr[1:0];
    for (int unsigned i = 0; i < NCH; i++)
      unused_lsb = unused_lsb ^ (^ch_addr[i*ADDR_W +: 2]);
  end

  always_ff @(posedge clk) begin
    if (any_gnt && wr_en)
      for (int unsigned b = 0; b < BE_W; b++)
        if (wr_be[b]) mem[word][b*8 +: 8] <= wr_data[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= PTR_W'(NUM_CH - 1);
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      ch_rvalid  <= '0;
      cpu_rdata  <= '0;
      ch_rdata   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (|gnt_ch && !lock_hold) rr_ptr <= sel;
      if (cpu_req && !gnt_cpu) begin
        if (starve_cnt != CNT_W'(MAX_WAIT)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      cpu_rvalid <= gnt_cpu && !cpu_we;
      ch_rvalid  <= gnt_ch & ~ch_we;
      if (gnt_cpu && !cpu_we)        cpu_rdata <= mem[word];
      if (|gnt_ch && !ch_we[sel])    ch_rdata  <= mem[word];
    end
  end

`ifdef RV32_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         cpu_stall_cnt <= '0;
    else if (stats_clr)                                 cpu_stall_cnt <= '0;
    else if (cpu_req && !gnt_cpu && cpu_stall_cnt != '1) cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
  end
`endif

  assign cpu_gnt = gnt_cpu;
  assign ch_gnt  = gnt_ch;

endmodule

// File: tb/tb_rv32_shared_sram_arb.sv
// Scoreboard bench for rv32_shared_sram_arb: read expectations queued at grant, checked at rvalid.
module tb_rv32_shared_sram_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [3:0]  ch_req = '0, ch_lock = '0, ch_we = '0;
  logic [63:0] ch_addr = '0;
  logic [127:0] ch_wdata = '0;
  logic [3:0]  ch_gnt, ch_rvalid;
  logic [31:0] ch_rdata;
`ifdef RV32_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] cpu_stall_cnt;
`endif

  rv32_shared_sram_arb #(.NUM_CH(4), .ADDR_W(16), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ch_req(ch_req), .ch_lock(ch_lock), .ch_addr(ch_addr), .ch_we(ch_we), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata)
`ifdef RV32_ARB_STATS_EN
    , .stats_clr(stats_clr), .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [31:0] data; } ch_exp_t;
  logic [31:0] cpu_q [$];
  ch_exp_t     ch_q [$];
  logic [31:0] model [0:16383];
  int vectors = 0, miscompares = 0;

  // Scoreboard: pop on rvalid (previous grant), then record this cycle's grant.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    ch_exp_t     ce;
    logic [3:0]  oh;
    logic [13:0] w;
    if (rst_n) begin
      if (cpu_rvalid) begin
        vectors++;
        if (cpu_q.size() == 0) begin
          miscompares++; $display("FAIL sb_cpu_unexpected: rvalid with rdata=%h, none expected", cpu_rdata);
        end else begin
          e = cpu_q.pop_front();
          if (cpu_rdata !== e) begin
            miscompares++; $display("FAIL sb_cpu_rdata: got %h expected %h", cpu_rdata, e);
          end
        end
      end
      if (|ch_rvalid) begin
        vectors++;
        if (ch_q.size() == 0) begin
          miscompares++; $display("FAIL sb_ch_unexpected: rvalid=%b none expected", ch_rvalid);
        end else begin
          ce = ch_q.pop_front();
          oh = 4'b0001 << ce.ch;
          if (ch_rvalid !== oh || ch_rdata !== ce.data) begin
            miscompares++;
            $display("FAIL sb_ch_rdata: got rvalid=%b data=%h expected rvalid=%b data=%h", ch_rvalid, ch_rdata, oh, ce.data);
          end
        end
      end
      vectors++;
      if (!$onehot0({cpu_gnt, ch_gnt})) begin
        miscompares++; $display("FAIL grant_onehot: cpu_gnt=%b ch_gnt=%b expected at most one", cpu_gnt, ch_gnt);
      end
      if (cpu_gnt === 1'b1) begin
        w = cpu_addr[15:2];
        if (cpu_we) begin
          for (int b = 0; b < 4; b++) if (cpu_be[b]) model[w][b*8 +: 8] = cpu_wdata[b*8 +: 8];
        end else cpu_q.push_back(model[w]);
      end
      for (int i = 0; i < 4; i++) if (ch_gnt[i] === 1'b1) begin
        w = ch_addr[i*16 + 2 +: 14];
        if (ch_we[i]) model[w] = ch_wdata[i*32 +: 32];
        else begin ce.ch = i; ce.data = model[w]; ch_q.push_back(ce); end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; cpu_req = 1'b0; ch_req = '0; ch_lock = '0; ch_we = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cpu_q.delete(); ch_q.delete();
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
    int n = 0;
    logic g = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    while (!g && n < 40) begin @(negedge clk); n++; g = cpu_gnt; end
    vectors++;
    if (!g) begin miscompares++; $display("FAIL cpu_gnt_timeout: got no grant in %0d cycles, required grant", n); end
    @(posedge clk); #1 cpu_req = 1'b0;
  endtask

  task automatic ch_access(input int ch, input logic we, input logic [15:0] a, input logic [31:0] wd);
    int n = 0;
    logic g = 1'b0;
    ch_req[ch] = 1'b1; ch_we[ch] = we; ch_addr[ch*16 +: 16] = a; ch_wdata[ch*32 +: 32] = wd;
    while (!g && n < 40) begin @(negedge clk); n++; g = ch_gnt[ch]; end
    vectors++;
    if (!g) begin miscompares++; $display("FAIL ch_gnt_timeout: ch%0d got no grant, required grant", ch); end
    @(posedge clk); #1 ch_req[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; ch_req = 4'hF;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ch_gnt, cpu_rvalid, ch_rvalid} !== 10'b0 || cpu_rdata !== 32'h0 || ch_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b/%b rvalid=%b/%b rdata=%h/%h, required all 0",
               cpu_gnt, ch_gnt, cpu_rvalid, ch_rvalid, cpu_rdata, ch_rdata);
    end
    do_reset();
  endtask

  task automatic test_cpu_rw();
    cpu_access(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    cpu_access(1'b1, 16'h0011, 4'b0010, 32'h0000AA00);
    cpu_access(1'b0, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADAAEF) begin
      miscompares++; $display("FAIL cpu_byte_lanes: rvalid=%b rdata=%h, required 1 DEADAAEF", cpu_rvalid, cpu_rdata);
    end
    @(negedge clk);
    vectors++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADAAEF) begin
      miscompares++; $display("FAIL cpu_rvalid_pulse: rvalid=%b rdata=%h, required 0 DEADAAEF held", cpu_rvalid, cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_access(1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    vectors++;
    if (cpu_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL write_no_rvalid: rvalid=%b, required 0", cpu_rvalid);
    end
    @(posedge clk); #1;
    cpu_access(1'b0, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 32'hDEADAAEF) begin
      miscompares++; $display("FAIL be_zero_write: rdata=%h, required DEADAAEF", cpu_rdata);
    end
    settle();
  endtask

  task automatic test_round_robin();
    logic [3:0] one = 4'b0001;
    for (int i = 0; i < 4; i++) cpu_access(1'b1, 16'(16'h0100 + 4*i), 4'hF, 32'hC0DE0000 + i);
    do_reset();
    for (int i = 0; i < 4; i++) ch_addr[i*16 +: 16] = 16'(16'h0100 + 4*i);
    ch_req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (ch_gnt !== (one << (k % 4)) || cpu_gnt !== 1'b0) begin
        miscompares++; $display("FAIL rr_order: cycle %0d ch_gnt=%b, required %b", k, ch_gnt, one << (k % 4));
      end
      if (k > 0) begin
        vectors++;
        if (ch_rvalid !== (one << ((k - 1) % 4))) begin
          miscompares++; $display("FAIL rr_rvalid: cycle %0d ch_rvalid=%b, required %b", k, ch_rvalid, one << ((k - 1) % 4));
        end
      end
    end
    @(posedge clk); #1 ch_req = '0;
    settle();
  endtask

  task automatic test_starvation();
    logic expc;
    do_reset();
    ch_addr[15:0] = 16'h0100; ch_req = 4'b0001;
    cpu_addr = 16'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      expc = (c == 9 || c == 18);
      vectors++;
      if (cpu_gnt !== expc || ch_gnt !== (expc ? 4'b0000 : 4'b0001)) begin
        miscompares++; $display("FAIL starvation: cycle %0d cpu_gnt=%b ch_gnt=%b, required cpu_gnt=%b", c, cpu_gnt, ch_gnt, expc);
      end
    end
    @(posedge clk); #1 cpu_req = 1'b0; ch_req = '0;
    settle();
  endtask

  task automatic test_lock();
    do_reset();
    ch_addr[15:0] = 16'h0100; ch_addr[31:16] = 16'h0104; ch_addr[47:32] = 16'h0108;
    ch_req = 4'b0100; ch_lock = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++;
      if (ch_gnt !== 4'b0100) begin
        miscompares++; $display("FAIL lock_hold: beat %0d ch_gnt=%b, required 0100", c, ch_gnt);
      end
      @(posedge clk); #1 ch_req = (c < 5) ? 4'b0111 : 4'b0011;
      if (c == 5) ch_lock = '0;
    end
    @(negedge clk);
    vectors++;
    if (ch_gnt !== 4'b0001) begin miscompares++; $display("FAIL lock_release0: ch_gnt=%b, required 0001", ch_gnt); end
    @(posedge clk); #1 ch_req = 4'b0010;
    @(negedge clk);
    vectors++;
    if (ch_gnt !== 4'b0010) begin miscompares++; $display("FAIL lock_release1: ch_gnt=%b, required 0010", ch_gnt); end
    @(posedge clk); #1 ch_req = '0;
    settle();
  endtask

  task automatic test_lock_starve();
    logic expc;
    do_reset();
    ch_addr[15:0] = 16'h0100; ch_addr[47:32] = 16'h0108;
    ch_req = 4'b0100; ch_lock = 4'b0100;
    cpu_addr = 16'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      expc = (c == 9);
      vectors++;
      if (cpu_gnt !== expc || ch_gnt !== (expc ? 4'b0000 : 4'b0100)) begin
        miscompares++; $display("FAIL lock_starve: cycle %0d cpu_gnt=%b ch_gnt=%b, required cpu_gnt=%b ch2 otherwise", c, cpu_gnt, ch_gnt, expc);
      end
      if (c == 1) begin @(posedge clk); #1 ch_req = 4'b0101; end
    end
    @(posedge clk); #1 cpu_req = 1'b0; ch_req = '0; ch_lock = '0;
    settle();
  endtask

  task automatic test_wrap();
    logic [16:0] a17 = 17'h1_0004;
    cpu_access(1'b1, a17[15:0], 4'hF, 32'h12345678);
    cpu_access(1'b0, 16'h0004, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 32'h12345678) begin miscompares++; $display("FAIL addr_wrap: rdata=%h, required 12345678", cpu_rdata); end
    @(posedge clk); #1;
    ch_access(1, 1'b1, 16'h0006, 32'hA5A55A5A);
    cpu_access(1'b0, 16'h0007, 4'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (cpu_rdata !== 32'hA5A55A5A) begin miscompares++; $display("FAIL addr_lsb_ignored: rdata=%h, required A5A55A5A", cpu_rdata); end
    @(posedge clk); #1;
    cpu_access(1'b1, 16'hFFFC, 4'hF, 32'hFEEDFACE);
    ch_access(3, 1'b0, 16'hFFFF, 32'h0);
    @(negedge clk);
    vectors++;
    if (ch_rvalid !== 4'b1000 || ch_rdata !== 32'hFEEDFACE) begin
      miscompares++; $display("FAIL top_word: ch_rvalid=%b ch_rdata=%h, required 1000 FEEDFACE", ch_rvalid, ch_rdata);
    end
    settle();
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    logic g = 1'b0;
    ch_access(0, 1'b0, 16'h0100, 32'h0);
    settle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    while (!g && n < 40) begin @(negedge clk); n++; g = cpu_gnt; end
    vectors++;
    if (!g) begin miscompares++; $display("FAIL midread_gnt_timeout: no grant, required grant"); end
    @(posedge clk); #1 rst_n = 1'b0; ch_req = 4'hF;
    for (int i = 0; i < 4; i++) ch_addr[i*16 +: 16] = 16'(16'h0100 + 4*i);
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ch_gnt, cpu_rvalid, ch_rvalid} !== 10'b0 || cpu_rdata !== 32'h0 || ch_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midread_reset: gnt=%b/%b rvalid=%b/%b rdata=%h/%h, required all 0",
               cpu_gnt, ch_gnt, cpu_rvalid, ch_rvalid, cpu_rdata, ch_rdata);
    end
    cpu_q.delete(); ch_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (ch_gnt !== 4'b0001 || cpu_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_first: ch_gnt=%b cpu_rvalid=%b, required 0001 0", ch_gnt, cpu_rvalid);
    end
    @(posedge clk); #1 ch_req = '0;
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_rw();
    test_round_robin();
    test_starvation();
    test_lock();
    test_lock_starve();
    test_wrap();
    test_reset_mid_read();
    vectors++;
    if (cpu_q.size() != 0 || ch_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d cpu and %0d ch reads outstanding, required 0", cpu_q.size(), ch_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
